// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control block.
package riscv_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// Opcode to immediate-format decode plus supported-opcode flag.
module instr_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  i_op,
  output logic [SEL_W-1:0] o_imm_src,
  output logic             o_op_valid
);

  // Immediate format and validity per opcode; R-type has no immediate.
  always_comb begin
    o_imm_src  = IMM_I;
    o_op_valid = 1'b0;
    case (i_op)
      OP_LW:  begin o_imm_src = IMM_I; o_op_valid = 1'b1; end
      OP_I:   begin o_imm_src = IMM_I; o_op_valid = 1'b1; end
      OP_SW:  begin o_imm_src = IMM_S; o_op_valid = 1'b1; end
      OP_BEQ: begin o_imm_src = IMM_B; o_op_valid = 1'b1; end
      OP_JAL: begin o_imm_src = IMM_J; o_op_valid = 1'b1; end
      OP_R:   begin o_imm_src = IMM_I; o_op_valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM sequencing the shared multicycle RV32I datapath.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [OP_W-1:0]  i_op,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_adr_src,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic [SEL_W-1:0] o_result_src,
  output logic [SEL_W-1:0] o_alu_src_a,
  output logic [SEL_W-1:0] o_alu_src_b,
  output logic [SEL_W-1:0] o_alu_op,
  output logic [SEL_W-1:0] o_imm_src,
  output logic             o_reg_write,
  output logic             o_instr_done,
  output logic             o_illegal
);

  state_t state;
  state_t state_next;
  logic   op_valid;

  instr_decoder u_instr_decoder (
    .i_op       (i_op),
    .o_imm_src  (o_imm_src),
    .o_op_valid (op_valid)
  );

  // State register; reset wins from any state, including stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Moore outputs, gated by ready/zero where the state needs it.
  always_comb begin
    state_next   = state;
    o_pc_write   = 1'b0;
    o_adr_src    = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_result_src = RES_ALUOUT;
    o_alu_src_a  = SRCA_PC;
    o_alu_src_b  = SRCB_RS2;
    o_alu_op     = ALUOP_ADD;
    o_reg_write  = 1'b0;
    o_instr_done = 1'b0;
    o_illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURESULT;
        o_ir_write   = i_mem_ready;
        o_pc_write   = i_mem_ready;
        if (i_mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
        if (!op_valid) begin
          o_illegal  = 1'b1;
          state_next = S_FETCH;
        end else begin
          case (i_op)
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_R:         state_next = S_EXECR;
            OP_I:         state_next = S_EXECI;
            OP_JAL:       state_next = S_JAL;
            OP_BEQ:       state_next = S_BEQ;
            default:      state_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
        if (i_op == OP_SW) state_next = S_MEMWRITE;
        else if (i_op == OP_LW) state_next = S_MEMREAD;
        else state_next = S_FETCH;
      end
      S_MEMREAD: begin
        o_adr_src = 1'b1;
        if (i_mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_result_src = RES_DATA;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        o_adr_src    = 1'b1;
        o_mem_write  = 1'b1;
        o_instr_done = i_mem_ready;
        if (i_mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_RS2;
        o_alu_op    = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_EXECI: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = ALUOP_FUNCT;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        o_result_src = RES_ALUOUT;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        state_next   = S_FETCH;
      end
      S_JAL: begin
        o_alu_src_a  = SRCA_OLDPC;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALUOUT;
        o_pc_write   = 1'b1;
        state_next   = S_ALUWB;
      end
      S_BEQ: begin
        o_alu_src_a  = SRCA_RS1;
        o_alu_src_b  = SRCB_RS2;
        o_alu_op     = ALUOP_SUB;
        o_result_src = RES_ALUOUT;
        o_pc_write   = i_zero;
        o_instr_done = 1'b1;
        state_next   = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // No architectural side effects while reset is held.
    if (i_rst) begin
      o_pc_write   = 1'b0;
      o_ir_write   = 1'b0;
      o_mem_write  = 1'b0;
      o_reg_write  = 1'b0;
      o_instr_done = 1'b0;
      o_illegal    = 1'b0;
    end
  end

endmodule
